// File: rtl/seq_divider_pkg.sv
// Shared types and constants for the sequential signed divider.
package seq_divider_pkg;

    // Default operand width of the divider.
    localparam int unsigned DIV_W = 16;

    // Width of an iteration counter able to count 0 .. w-1.
    function automatic int unsigned cnt_width(input int unsigned w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

    localparam int unsigned CNT_W = cnt_width(DIV_W);

    // Most negative value at the default width; its magnitude is 2^(W-1).
    localparam logic [DIV_W-1:0] MIN_NEG = {1'b1, {(DIV_W-1){1'b0}}};

    typedef enum logic [1:0] {
        StIdle,
        StCalc,
        StFix,
        StDone
    } div_state_e;

endpackage

// File: rtl/seq_divider_addsub.sv
// Ripple adder/subtractor: s = a + (b ^ {W{c0}}) + c0, so c0 = 1 subtracts.
module seq_divider_addsub #(
    parameter int unsigned W = 16
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         c0,
    output logic [W-1:0] s
);

    logic [W-1:0] b_x;
    logic [W:0]   carry;

    // Bitwise full-adder chain with the operand conditionally inverted.
    always_comb begin
        b_x      = b ^ {W{c0}};
        carry    = '0;
        carry[0] = c0;
        s        = '0;
        for (int i = 0; i < int'(W); i++) begin
            s[i]       = a[i] ^ b_x[i] ^ carry[i];
            carry[i+1] = (a[i] & b_x[i]) | (carry[i] & (a[i] ^ b_x[i]));
        end
    end

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle signed divider: one restoring step per clock on operand magnitudes,
// then a single sign-correction cycle. Truncates toward zero; remainder follows dividend.
module seq_divider
    import seq_divider_pkg::*;
#(
    parameter int unsigned W = DIV_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [W-1:0] A,
    input  logic [W-1:0] B,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] Q,
    output logic [W-1:0] Rem,
    output logic         dz,
    output logic         ovf
);

    localparam int unsigned CntW = cnt_width(W);
    localparam logic [W-1:0] MinNeg = {1'b1, {(W-1){1'b0}}};
    localparam logic [CntW-1:0] LastIter = CntW'(W - 1);

    div_state_e    state_q;
    // Holds |A| and shifts left each step; quotient bits enter at the LSB,
    // so after W steps it holds the quotient magnitude.
    logic [W-1:0]  a_q;
    logic [W-1:0]  b_q;
    // Partial remainder; after an accepted step it is always below |B|, so the
    // W+1th bit of P is never set between steps and is not stored.
    logic [W-1:0]  p_q;
    logic [CntW-1:0] cnt_q;
    logic          sign_a_q;
    logic          sign_b_q;
    logic          ovf_pend_q;

    logic [W-1:0]  abs_a;
    logic [W-1:0]  abs_b;
    logic [W:0]    p_shift;
    logic [W:0]    trial;
    logic [W-1:0]  neg_quo;
    logic [W-1:0]  neg_rem;

    // Magnitudes as W-bit unsigned; |MinNeg| maps onto itself, which is correct.
    assign abs_a   = A[W-1] ? (~A + W'(1)) : A;
    assign abs_b   = B[W-1] ? (~B + W'(1)) : B;

    assign p_shift = {p_q, a_q[W-1]};

    seq_divider_addsub #(
        .W (W + 1)
    ) u_trial_sub (
        .a  (p_shift),
        .b  ({1'b0, b_q}),
        .c0 (1'b1),
        .s  (trial)
    );

    seq_divider_addsub #(
        .W (W)
    ) u_neg_quo (
        .a  ('0),
        .b  (a_q),
        .c0 (1'b1),
        .s  (neg_quo)
    );

    seq_divider_addsub #(
        .W (W)
    ) u_neg_rem (
        .a  ('0),
        .b  (p_q),
        .c0 (1'b1),
        .s  (neg_rem)
    );

    // Control FSM with registered outputs; results only update on entry to StDone.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            busy       <= 1'b0;
            done       <= 1'b0;
            Q          <= '0;
            Rem        <= '0;
            dz         <= 1'b0;
            ovf        <= 1'b0;
            a_q        <= '0;
            b_q        <= '0;
            p_q        <= '0;
            cnt_q      <= '0;
            sign_a_q   <= 1'b0;
            sign_b_q   <= 1'b0;
            ovf_pend_q <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        if (B == '0) begin
                            Q       <= '1;
                            Rem     <= A;
                            dz      <= 1'b1;
                            ovf     <= 1'b0;
                            done    <= 1'b1;
                            state_q <= StDone;
                        end else begin
                            a_q        <= abs_a;
                            b_q        <= abs_b;
                            p_q        <= '0;
                            cnt_q      <= '0;
                            sign_a_q   <= A[W-1];
                            sign_b_q   <= B[W-1];
                            ovf_pend_q <= (A == MinNeg) && (B == '1);
                            busy       <= 1'b1;
                            state_q    <= StCalc;
                        end
                    end
                end
                StCalc: begin
                    // Negative trial result means |B| did not fit: keep P.
                    if (!trial[W]) begin
                        p_q <= trial[W-1:0];
                    end else begin
                        p_q <= p_shift[W-1:0];
                    end
                    a_q   <= {a_q[W-2:0], ~trial[W]};
                    cnt_q <= cnt_q + CntW'(1);
                    if (cnt_q == LastIter) begin
                        state_q <= StFix;
                    end
                end
                StFix: begin
                    Q       <= (sign_a_q ^ sign_b_q) ? neg_quo : a_q;
                    Rem     <= sign_a_q ? neg_rem : p_q;
                    dz      <= 1'b0;
                    ovf     <= ovf_pend_q;
                    busy    <= 1'b0;
                    done    <= 1'b1;
                    state_q <= StDone;
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: directed table, random vs. arithmetic model,
// and hand-written multi-cycle sequences (held start, mid-operation reset).
module tb_seq_divider;

    localparam int W = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [W-1:0]  a_in;
    logic [W-1:0]  b_in;
    logic          busy_w;
    logic          done_w;
    logic [W-1:0]  q_w;
    logic [W-1:0]  rem_w;
    logic          dz_w;
    logic          ovf_w;

    int            n_checks = 0;
    int            n_fail = 0;
    logic [W-1:0]  last_q = '0;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dz;
        logic         ovf;
    } vec_t;

    vec_t tbl[12];

    seq_divider #(
        .W (W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .A     (a_in),
        .B     (b_in),
        .busy  (busy_w),
        .done  (done_w),
        .Q     (q_w),
        .Rem   (rem_w),
        .dz    (dz_w),
        .ovf   (ovf_w)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // Reference: signed integer arithmetic plus the two special cases.
    function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] q, output logic [W-1:0] r,
                                  output logic dz_e, output logic ovf_e);
        int sa;
        int sb;
        sa    = int'($signed(a));
        sb    = int'($signed(b));
        dz_e  = 1'b0;
        ovf_e = 1'b0;
        if (sb == 0) begin
            q    = '1;
            r    = a;
            dz_e = 1'b1;
        end else if (sa == -32768 && sb == -1) begin
            q     = 16'h8000;
            r     = '0;
            ovf_e = 1'b1;
        end else begin
            q = 16'(sa / sb);
            r = 16'(sa % sb);
        end
    endfunction

    // One division: start at edge 0, scramble operands afterwards, time done and busy.
    task automatic run_check(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                             input logic [W-1:0] eq, input logic [W-1:0] er,
                             input logic edz, input logic eovf);
        int lat;
        int busy_cyc;
        logic [W-1:0] q_first;
        @(negedge clk);
        a_in  = a;
        b_in  = b;
        start = 1'b1;
        @(posedge clk);
        #1;
        start    = 1'b0;
        a_in     = W'($urandom);
        b_in     = W'($urandom);
        lat      = -1;
        busy_cyc = 0;
        q_first  = q_w;
        for (int c = 0; c < 40; c++) begin
            if (busy_w) busy_cyc++;
            if (done_w) begin
                lat = c;
                break;
            end
            @(posedge clk);
            #1;
        end
        if (!edz) chk({tag, ".q_held"}, 32'(q_first), 32'(last_q));
        chk({tag, ".latency"}, 32'(lat), edz ? 32'd0 : 32'(W + 1));
        chk({tag, ".busy_cycles"}, 32'(busy_cyc), edz ? 32'd0 : 32'(W + 1));
        chk({tag, ".q"}, 32'(q_w), 32'(eq));
        chk({tag, ".rem"}, 32'(rem_w), 32'(er));
        chk({tag, ".dz"}, 32'(dz_w), 32'(edz));
        chk({tag, ".ovf"}, 32'(ovf_w), 32'(eovf));
        last_q = eq;
        @(posedge clk);
        #1;
        chk({tag, ".done_pulse"}, 32'(done_w), 32'd0);
        chk({tag, ".q_hold"}, 32'(q_w), 32'(eq));
    endtask

    initial begin
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic [W-1:0] mq;
        logic [W-1:0] mr;
        logic         mdz;
        logic         movf;
        int           done_edges[$];
        logic [W-1:0] q_at_first;
        int           seen;

        tbl[0]  = '{16'd100,  16'd7,    16'd14,   16'd2,    1'b0, 1'b0};
        tbl[1]  = '{16'hFF9C, 16'd7,    16'hFFF2, 16'hFFFE, 1'b0, 1'b0};
        tbl[2]  = '{16'd100,  16'hFFF9, 16'hFFF2, 16'd2,    1'b0, 1'b0};
        tbl[3]  = '{16'hFF9C, 16'hFFF9, 16'd14,   16'hFFFE, 1'b0, 1'b0};
        tbl[4]  = '{16'd7,    16'd0,    16'hFFFF, 16'd7,    1'b1, 1'b0};
        tbl[5]  = '{16'h8000, 16'hFFFF, 16'h8000, 16'd0,    1'b0, 1'b1};
        tbl[6]  = '{16'h8000, 16'd1,    16'h8000, 16'd0,    1'b0, 1'b0};
        tbl[7]  = '{16'd0,    16'd5,    16'd0,    16'd0,    1'b0, 1'b0};
        tbl[8]  = '{16'h7FFF, 16'h8000, 16'd0,    16'h7FFF, 1'b0, 1'b0};
        tbl[9]  = '{16'h8000, 16'h8000, 16'd1,    16'd0,    1'b0, 1'b0};
        tbl[10] = '{16'hFFF9, 16'd0,    16'hFFFF, 16'hFFF9, 1'b1, 1'b0};
        tbl[11] = '{16'h7FFF, 16'd1,    16'h7FFF, 16'd0,    1'b0, 1'b0};

        rst_n = 1'b0;
        start = 1'b0;
        a_in  = '0;
        b_in  = '0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("reset.busy", 32'(busy_w), 32'd0);
        chk("reset.done", 32'(done_w), 32'd0);
        chk("reset.q", 32'(q_w), 32'd0);
        chk("reset.rem", 32'(rem_w), 32'd0);
        chk("reset.dz", 32'(dz_w), 32'd0);
        chk("reset.ovf", 32'(ovf_w), 32'd0);

        for (int i = 0; i < 12; i++) begin
            run_check($sformatf("tbl%0d", i), tbl[i].a, tbl[i].b, tbl[i].q, tbl[i].r,
                      tbl[i].dz, tbl[i].ovf);
        end

        for (int i = 0; i < 40; i++) begin
            ra = W'($urandom);
            case ($urandom_range(0, 5))
                0:       rb = '0;
                1:       rb = W'($urandom_range(1, 20));
                2:       rb = -W'($urandom_range(1, 20));
                3: begin
                    ra = 16'h8000;
                    rb = W'($urandom);
                end
                default: rb = W'($urandom);
            endcase
            model(ra, rb, mq, mr, mdz, movf);
            run_check($sformatf("rnd%0d", i), ra, rb, mq, mr, mdz, movf);
        end

        // start held high: 50/5 runs, 9/3 only accepted on the first IDLE cycle.
        @(negedge clk);
        a_in  = 16'd50;
        b_in  = 16'd5;
        start = 1'b1;
        @(posedge clk);
        #1;
        a_in       = 16'd9;
        b_in       = 16'd3;
        q_at_first = '0;
        for (int e = 0; e <= 2 * W + 4; e++) begin
            if (done_w) begin
                done_edges.push_back(e);
                if (done_edges.size() == 1) q_at_first = q_w;
            end
            if (e == 2 * W + 4) start = 1'b0;
            else begin
                @(posedge clk);
                #1;
            end
        end
        chk("hold.done_count", 32'(done_edges.size()), 32'd2);
        chk("hold.first_q", 32'(q_at_first), 32'd10);
        chk("hold.first_edge", (done_edges.size() > 0) ? 32'(done_edges[0]) : 32'hFFFF_FFFF,
            32'(W + 1));
        chk("hold.second_edge", (done_edges.size() > 1) ? 32'(done_edges[1]) : 32'hFFFF_FFFF,
            32'(2 * W + 4));
        chk("hold.second_q", 32'(q_w), 32'd3);
        chk("hold.second_rem", 32'(rem_w), 32'd0);
        last_q = 16'd3;
        repeat (3) @(posedge clk);
        #1;

        // Reset asserted at edge 8 of a division aborts it silently.
        @(negedge clk);
        a_in  = 16'd1000;
        b_in  = 16'd3;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        chk("rst.busy_before", 32'(busy_w), 32'd1);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("rst.busy", 32'(busy_w), 32'd0);
        chk("rst.q", 32'(q_w), 32'd0);
        chk("rst.rem", 32'(rem_w), 32'd0);
        chk("rst.dz_ovf", 32'({dz_w, ovf_w}), 32'd0);
        seen = 0;
        for (int c = 0; c < 25; c++) begin
            if (done_w || busy_w) seen++;
            @(posedge clk);
            #1;
        end
        chk("rst.no_done", 32'(seen), 32'd0);
        last_q = '0;
        run_check("after_rst", 16'd1000, 16'd3, 16'd333, 16'd1, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
